hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Hazard detection/stall controller for the 5-stage RISC-V pipeline; counterpart of the EX-stage forwarding unit.
//  Forwarding resolves hazards by bypassing; this block handles the cases bypassing cannot.
//  It stalls the IF/ID stages on load-use, flushes on a taken branch and freezes on memory not-ready.
//  It sits in ID and drives the PC, IF/ID and ID/EX register enables and flushes.
// PARAMETERS
//  REG_W        5   register-index width
//  LOAD_STALLS  1   bubbles per load-use hazard (>=1); set >1 for slow data memory
//  FLUSH_CYCLES 1   cycles IF/ID+ID/EX flushed after a taken branch (>=1)
//  CNT_W        16  width of stall performance counter
// PORTS
//  clk              in   1      rising-edge clock
//  reset_L          in   1      asynchronous, active-low reset
//  ID_EX_MemRead    in   1      instruction in EX is a load
//  ID_EX_Rd         in   REG_W  destination of instruction in EX
//  IF_ID_Rs1        in   REG_W  source 1 of instruction in ID
//  IF_ID_Rs2        in   REG_W  source 2 of instruction in ID
//  IF_ID_UsesRs2    in   1      ID instruction reads Rs2 (R/S/B type)
//  EX_BranchTaken   in   1      branch/jump in EX resolved taken
//  Mem_Ready        in   1      data memory can accept/complete access
//  PC_Write         out  1      PC register enable
//  IF_ID_Write      out  1      IF/ID register enable
//  IF_ID_Flush      out  1      convert IF/ID contents to NOP
//  ID_EX_Flush      out  1      insert bubble (zero controls) into ID/EX
//  Stall_Count      out  CNT_W  cycles with PC_Write==0 since reset, saturating
// BEHAVIOUR
//  Reset (reset_L=0, async): state=RUN, cnt=0, Stall_Count=0; outputs PC_Write=0, IF_ID_Write=0,
//   IF_ID_Flush=1, ID_EX_Flush=1; normal outputs from the first clk edge after deassertion.
//  load_use = ID_EX_MemRead & (ID_EX_Rd!=0) & ((ID_EX_Rd==IF_ID_Rs1) | (IF_ID_UsesRs2 & ID_EX_Rd==IF_ID_Rs2)).
//  Outputs are combinational from state+inputs (Mealy); state, cnt and Stall_Count are registered.
//  FSM states: RUN, LOAD_STALL, BR_FLUSH. Priority per cycle: freeze > branch > load-use.
//  Freeze (Mem_Ready=0, any state): PC_Write=0, IF_ID_Write=0, both flushes 0; state and cnt hold.
//  RUN:
//   EX_BranchTaken: PC_Write=1, IF_ID_Flush=1, ID_EX_Flush=1.
//    Next state is BR_FLUSH with cnt=FLUSH_CYCLES-2 if FLUSH_CYCLES>1, else RUN.
//   else load_use: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
//    Next state is LOAD_STALL with cnt=LOAD_STALLS-2 if LOAD_STALLS>1, else RUN.
//   else: PC_Write=1, IF_ID_Write=1, flushes 0.
//  LOAD_STALL: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; cnt==0 -> RUN, else cnt-1.
//   EX_BranchTaken here is treated exactly as in RUN (defensive; it aborts the stall).
//  BR_FLUSH: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1; cnt==0 -> RUN, else cnt-1.
//   A new EX_BranchTaken reloads cnt=FLUSH_CYCLES-2 (restart).
//  Latency: hazard detected and acted on in the same cycle; zero added latency when no hazard.
//  Stall_Count increments on each clk edge where PC_Write==0 (freeze included); holds at 2^CNT_W-1.
//  Rd==x0 never creates a load-use hazard. IF_ID_Write and PC_Write always equal except in reset.
// STRUCTURE
//  hazard_pkg: typedef enum logic [1:0] {RUN, LOAD_STALL, BR_FLUSH} hz_state_t; REG_W default constant.
//  Sub-module hazard_cmp: combinational load_use comparator (Rd vs Rs1/Rs2, x0 and UsesRs2 masking).
//  Top: FSM + down-counter (width $clog2(max(LOAD_STALLS,FLUSH_CYCLES))+1) + saturating Stall_Count.
// TESTING
//  1 MemRead=1, Rd=5, Rs1=5, Mem_Ready=1 -> same cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1;
//    next cycle (MemRead=0) PC_Write=1; Stall_Count=1.
//  2 MemRead=1, Rd=0, Rs1=0 -> no stall; Rd=7, Rs2=7, UsesRs2=0 -> no stall; UsesRs2=1 -> stall.
//  3 LOAD_STALLS=3, load-use once -> exactly 3 cycles PC_Write=0, then RUN; Stall_Count=3.
//  4 EX_BranchTaken=1 with load_use=1 in same cycle -> PC_Write=1, both flushes 1 (branch wins);
//    FLUSH_CYCLES=2 -> flushes held 2 cycles total.
//  5 Mem_Ready=0 for 4 cycles mid LOAD_STALL -> all enables/flushes 0, cnt frozen, stall resumes after;
//    Stall_Count grows by 4 plus the stall cycles.
//  6 reset_L low mid BR_FLUSH (async, between edges) -> immediate reset outputs, Stall_Count=0, RUN after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard/stall controller.
package hazard_pkg;
   typedef enum logic [1:0] {RUN, LOAD_STALL, BR_FLUSH} hz_state_t;
   localparam int REG_W_DEF = 5;
endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: EX-stage load destination against ID-stage sources.
module hazard_cmp
   import hazard_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
) (
   input  logic             mem_read,
   input  logic [REG_W-1:0] rd,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic             uses_rs2,
   output logic             load_use
);
   // x0 is hardwired zero, so a load into it never creates a dependency
   assign load_use = mem_read && (rd != '0) &&
                     ((rd == rs1) || (uses_rs2 && (rd == rs2)));
endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use stalls, taken-branch flushes, memory freeze.
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int REG_W        = REG_W_DEF,
   parameter int LOAD_STALLS  = 1,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             ID_EX_MemRead,
   input  logic [REG_W-1:0] ID_EX_Rd,
   input  logic [REG_W-1:0] IF_ID_Rs1,
   input  logic [REG_W-1:0] IF_ID_Rs2,
   input  logic             IF_ID_UsesRs2,
   input  logic             EX_BranchTaken,
   input  logic             Mem_Ready,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic [CNT_W-1:0] Stall_Count
);
   localparam int MAXC = (LOAD_STALLS > FLUSH_CYCLES) ? LOAD_STALLS : FLUSH_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam int LS_I = (LOAD_STALLS > 1) ? LOAD_STALLS - 2 : 0;
   localparam int FL_I = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
   localparam logic [CW-1:0] LS_INIT = CW'(LS_I);
   localparam logic [CW-1:0] FL_INIT = CW'(FL_I);
   localparam hz_state_t LS_NEXT = (LOAD_STALLS > 1) ? LOAD_STALL : RUN;
   localparam hz_state_t FL_NEXT = (FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;

   hz_state_t       state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            load_use;
   logic            pc_wr, ifid_wr, ifid_fl, idex_fl;

   hazard_cmp #(.REG_W(REG_W)) u_cmp (
      .mem_read (ID_EX_MemRead),
      .rd       (ID_EX_Rd),
      .rs1      (IF_ID_Rs1),
      .rs2      (IF_ID_Rs2),
      .uses_rs2 (IF_ID_UsesRs2),
      .load_use (load_use)
   );

   // Priority: freeze > branch (from any state) > per-state action
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pc_wr     = 1'b1;
      ifid_wr   = 1'b1;
      ifid_fl   = 1'b0;
      idex_fl   = 1'b0;
      if (!Mem_Ready) begin
         pc_wr   = 1'b0;
         ifid_wr = 1'b0;
      end else if (EX_BranchTaken) begin
         ifid_fl   = 1'b1;
         idex_fl   = 1'b1;
         state_nxt = FL_NEXT;
         cnt_nxt   = FL_INIT;
      end else begin
         case (state)
            BR_FLUSH: begin
               ifid_fl = 1'b1;
               idex_fl = 1'b1;
               if (cnt == '0) state_nxt = RUN;
               else           cnt_nxt   = cnt - 1'b1;
            end
            LOAD_STALL: begin
               pc_wr   = 1'b0;
               ifid_wr = 1'b0;
               idex_fl = 1'b1;
               if (cnt == '0) state_nxt = RUN;
               else           cnt_nxt   = cnt - 1'b1;
            end
            default: begin
               if (load_use) begin
                  pc_wr     = 1'b0;
                  ifid_wr   = 1'b0;
                  idex_fl   = 1'b1;
                  state_nxt = LS_NEXT;
                  cnt_nxt   = LS_INIT;
               end
            end
         endcase
      end
   end

   // Reset forces the pipeline into a held, bubbled state without waiting for a clock
   assign PC_Write    = reset_L & pc_wr;
   assign IF_ID_Write = reset_L & ifid_wr;
   assign IF_ID_Flush = ~reset_L | ifid_fl;
   assign ID_EX_Flush = ~reset_L | idex_fl;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state       <= RUN;
         cnt         <= '0;
         Stall_Count <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (!pc_wr && (Stall_Count != '1))
            Stall_Count <= Stall_Count + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: three instances (default, slow-memory, narrow counter).
module tb_hazard_stall_unit;
   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic       mr = 1'b0, u2 = 1'b0, br = 1'b0, rdy = 1'b1;
   logic [4:0] rd = '0, rs1 = '0, rs2 = '0;

   logic        pc1, ifw1, iff1, idf1, pc3, ifw3, iff3, idf3, pcs, ifws, iffs, idfs;
   logic [15:0] cnt1, cnt3;
   logic [2:0]  cnts;

   always #5 clk = ~clk;

   hazard_stall_unit dut1 (
      .clk(clk), .reset_L(reset_L), .ID_EX_MemRead(mr), .ID_EX_Rd(rd), .IF_ID_Rs1(rs1),
      .IF_ID_Rs2(rs2), .IF_ID_UsesRs2(u2), .EX_BranchTaken(br), .Mem_Ready(rdy),
      .PC_Write(pc1), .IF_ID_Write(ifw1), .IF_ID_Flush(iff1), .ID_EX_Flush(idf1),
      .Stall_Count(cnt1));

   hazard_stall_unit #(.LOAD_STALLS(3), .FLUSH_CYCLES(2)) dut3 (
      .clk(clk), .reset_L(reset_L), .ID_EX_MemRead(mr), .ID_EX_Rd(rd), .IF_ID_Rs1(rs1),
      .IF_ID_Rs2(rs2), .IF_ID_UsesRs2(u2), .EX_BranchTaken(br), .Mem_Ready(rdy),
      .PC_Write(pc3), .IF_ID_Write(ifw3), .IF_ID_Flush(iff3), .ID_EX_Flush(idf3),
      .Stall_Count(cnt3));

   hazard_stall_unit #(.CNT_W(3)) duts (
      .clk(clk), .reset_L(reset_L), .ID_EX_MemRead(mr), .ID_EX_Rd(rd), .IF_ID_Rs1(rs1),
      .IF_ID_Rs2(rs2), .IF_ID_UsesRs2(u2), .EX_BranchTaken(br), .Mem_Ready(rdy),
      .PC_Write(pcs), .IF_ID_Write(ifws), .IF_ID_Flush(iffs), .ID_EX_Flush(idfs),
      .Stall_Count(cnts));

   int n_vec = 0, n_err = 0;

   // Reference model: remaining stall/flush cycles per instance, plain integers
   int m_l[3]   = '{1, 3, 1};
   int m_f[3]   = '{1, 2, 1};
   int m_max[3] = '{65535, 65535, 7};
   int m_ls[3], m_fl[3], m_cnt[3], n_ls[3], n_fl[3];
   logic [3:0] e_out[3];
   logic [3:0] s_out[3];
   int         s_cnt[3];

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
      end
   endtask

   task automatic set_in(input logic imr, input logic [4:0] ird, input logic [4:0] irs1,
                         input logic [4:0] irs2, input logic iu2, input logic ibr, input logic irdy);
      mr = imr; rd = ird; rs1 = irs1; rs2 = irs2; u2 = iu2; br = ibr; rdy = irdy;
   endtask

   task automatic idle();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic model_eval(input int k);
      bit lu;
      lu = mr && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
      n_ls[k] = m_ls[k];
      n_fl[k] = m_fl[k];
      if (!rdy) e_out[k] = 4'b0000;
      else if (br) begin
         e_out[k] = 4'b1111; n_ls[k] = 0; n_fl[k] = m_f[k] - 1;
      end else if (m_fl[k] > 0) begin
         e_out[k] = 4'b1111; n_fl[k] = m_fl[k] - 1;
      end else if (m_ls[k] > 0) begin
         e_out[k] = 4'b0001; n_ls[k] = m_ls[k] - 1;
      end else if (lu) begin
         e_out[k] = 4'b0001; n_ls[k] = m_l[k] - 1;
      end else e_out[k] = 4'b1100;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_ls[k] = 0; m_fl[k] = 0; m_cnt[k] = 0;
      end
   endtask

   // One clock: sample at negedge, check against the model, advance model at posedge
   task automatic cycle();
      @(negedge clk);
      s_out[0] = {pc1, ifw1, iff1, idf1};
      s_out[1] = {pc3, ifw3, iff3, idf3};
      s_out[2] = {pcs, ifws, iffs, idfs};
      s_cnt[0] = int'(cnt1); s_cnt[1] = int'(cnt3); s_cnt[2] = int'(cnts);
      for (int k = 0; k < 3; k++) begin
         model_eval(k);
         chk($sformatf("model_out[%0d]", k), 32'(s_out[k]), 32'(e_out[k]));
         chk($sformatf("model_cnt[%0d]", k), 32'(s_cnt[k]), 32'(m_cnt[k]));
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (!e_out[k][3] && m_cnt[k] < m_max[k]) m_cnt[k]++;
         m_ls[k] = n_ls[k];
         m_fl[k] = n_fl[k];
      end
      #1;
   endtask

   // Asserts reset between edges and checks its immediate effect
   task automatic do_reset();
      idle();
      #2 reset_L = 1'b0;
      #1;
      chk("rst_out1", 32'({pc1, ifw1, iff1, idf1}), 32'h3);
      chk("rst_out3", 32'({pc3, ifw3, iff3, idf3}), 32'h3);
      chk("rst_cnt1", 32'(cnt1), 32'd0);
      chk("rst_cnt3", 32'(cnt3), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset_L = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       mr;
      logic [4:0] rd, rs1, rs2;
      logic       u2, br, rdy;
      logic [3:0] exp;
   } vec_t;
   vec_t tbl[10];

   initial begin
      tbl[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 4'b0001};
      tbl[1] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 4'b1100};
      tbl[2] = '{1'b1, 5'd7,  5'd1,  5'd7,  1'b0, 1'b0, 1'b1, 4'b1100};
      tbl[3] = '{1'b1, 5'd7,  5'd1,  5'd7,  1'b1, 1'b0, 1'b1, 4'b0001};
      tbl[4] = '{1'b0, 5'd7,  5'd7,  5'd0,  1'b0, 1'b0, 1'b1, 4'b1100};
      tbl[5] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b1, 1'b1, 4'b1111};
      tbl[6] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b1, 1'b0, 4'b0000};
      tbl[7] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 4'b1111};
      tbl[8] = '{1'b1, 5'd31, 5'd3,  5'd31, 1'b1, 1'b0, 1'b1, 4'b0001};
      tbl[9] = '{1'b1, 5'd31, 5'd30, 5'd30, 1'b1, 1'b0, 1'b1, 4'b1100};

      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Table: default instance never leaves RUN, so each row is independent
      foreach (tbl[i]) begin
         set_in(tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].u2, tbl[i].br, tbl[i].rdy);
         cycle();
         chk($sformatf("tbl[%0d]", i), 32'(s_out[0]), 32'(tbl[i].exp));
      end

      // Load-use: single bubble on dut1, three on dut3
      do_reset();
      set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
      cycle();
      chk("lu_first1", 32'(s_out[0]), 32'h1);
      chk("lu_first3", 32'(s_out[1]), 32'h1);
      idle();
      cycle();
      chk("lu_after1", 32'(s_out[0]), 32'hC);
      chk("lu_cnt1", 32'(s_cnt[0]), 32'd1);
      chk("lu_hold3a", 32'(s_out[1]), 32'h1);
      cycle();
      chk("lu_hold3b", 32'(s_out[1]), 32'h1);
      cycle();
      chk("lu_done3", 32'(s_out[1]), 32'hC);
      chk("lu_cnt3", 32'(s_cnt[1]), 32'd3);

      // Branch beats load-use; dut3 keeps flushing for a second cycle
      do_reset();
      set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
      cycle();
      chk("br_lu1", 32'(s_out[0]), 32'hF);
      chk("br_lu3", 32'(s_out[1]), 32'hF);
      idle();
      cycle();
      chk("br_after1", 32'(s_out[0]), 32'hC);
      chk("br_hold3", 32'(s_out[1]), 32'hF);
      cycle();
      chk("br_done3", 32'(s_out[1]), 32'hC);

      // Freeze for 4 cycles in the middle of dut3's load stall
      do_reset();
      set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);
      cycle();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
         cycle();
         chk($sformatf("frz3[%0d]", i), 32'(s_out[1]), 32'h0);
      end
      idle();
      cycle();
      chk("frz_resume3a", 32'(s_out[1]), 32'h1);
      cycle();
      chk("frz_resume3b", 32'(s_out[1]), 32'h1);
      cycle();
      chk("frz_done3", 32'(s_out[1]), 32'hC);
      chk("frz_cnt3", 32'(s_cnt[1]), 32'd7);
      chk("frz_cnt1", 32'(s_cnt[0]), 32'd5);

      // Async reset while dut3 sits in its flush window
      do_reset();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      cycle();
      do_reset();
      cycle();
      chk("rst_mid_br3", 32'(s_out[1]), 32'hC);
      chk("rst_mid_cnt3", 32'(s_cnt[1]), 32'd0);

      // Saturation of a 3-bit counter
      do_reset();
      for (int i = 0; i < 10; i++) begin
         set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
         cycle();
      end
      idle();
      cycle();
      chk("sat_cnts", 32'(s_cnt[2]), 32'd7);
      chk("sat_cnt1", 32'(s_cnt[0]), 32'd10);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(0, 9) < 5), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) < 8));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
